// File: rtl/up2_uart_tx.sv
// up2_uart_tx: 8N1 UART transmitter with a small byte FIFO and back-to-back framing
module up2_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic [7:0]         data,
    input  logic               valid,
    output logic               ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   count
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];
    logic               push, pop, baud_end;

    assign ready    = count_q != (FIFO_AW + 1)'(DEPTH);
    assign push     = valid && ready;
    assign baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
    assign busy     = (state_q != IDLE) || (count_q != '0);
    assign count    = count_q;
    assign tx       = tx_q;

    // FIFO storage needs no reset: only entries counted by count_q are ever read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data;
    end

    // Framing FSM and FIFO bookkeeping; a pop reloads the shifter and drops tx for the start bit
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            default: begin
                baud_d = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    pop     = count_q != '0;
                    shift_d = pop ? mem_q[rd_ptr_q] : shift_q;
                    tx_d    = !pop;
                    state_d = pop ? START : IDLE;
                end
            end
        endcase
        wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        count_d  = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end

    // State registers; reset abandons any frame and parks tx high
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_up2_uart_tx.sv
// tb_up2_uart_tx: scoreboard bench decoding tx frames against the bytes accepted by the FIFO
module tb_up2_uart_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       nRst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, tx, busy;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rst_gen = 0;
    logic [9:0] sb [$];

    up2_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
        .clk(clk), .nRst(nRst), .data(data), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy), .count(count)
    );

    always #10 clk = ~clk;

    // Cycle stamp used to measure frame spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line receiver: samples mid-bit, compares each completed frame with the scoreboard head
    logic       mon_act = 1'b0;
    int         k = 0;
    int         seen_gen = 0;
    int         last_start = 0;
    int         prev_start = 0;
    logic [9:0] cap = '0;
    logic [9:0] exp_f;
    always @(negedge clk) begin
        if (seen_gen != rst_gen) begin
            seen_gen = rst_gen;
            mon_act = 1'b0;
            sb.delete();
        end else if (!mon_act) begin
            if (nRst && tx == 1'b0) begin
                mon_act = 1'b1;
                k = 0;
                prev_start = last_start;
                last_start = cyc;
            end
        end else begin
            k++;
            if (k % CPB == CPB / 2) cap[k / CPB] = tx;
            if (k == 10 * CPB - 1) begin
                mon_act = 1'b0;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL frame_unexpected: got %0h expected none", cap);
                end else begin
                    exp_f = sb.pop_front();
                    check("frame", 32'(cap), 32'(exp_f));
                end
            end
        end
    end

    // One push attempt: sentinel 0xEE is offered whenever the FIFO reports full
    task automatic push(input logic [7:0] d, input logic [9:0] f, output logic ok, output logic [2:0] c);
        @(negedge clk);
        ok = ready;
        c = count;
        data = ok ? d : 8'hEE;
        valid = 1'b1;
        if (ok) sb.push_back(f);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        valid = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && !mon_act && tx) break;
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tx", 32'(tx), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
        logic [2:0] cnt;
    } vec_t;

    vec_t       tbl [5];
    logic       ok;
    logic [2:0] c;
    logic [7:0] burst [6];
    int         n, i, guard, held;

    initial begin
        tbl[0] = '{8'h00, 10'h200, 3'd1};
        tbl[1] = '{8'hFF, 10'h3FE, 3'd1};
        tbl[2] = '{8'hA5, 10'h34A, 3'd1};
        tbl[3] = '{8'h3C, 10'h278, 3'd1};
        tbl[4] = '{8'hA3, 10'h346, 3'd1};
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};

        #1 nRst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        push(8'h55, 10'h2AA, ok, c);
        valid = 1'b0;
        @(negedge clk);
        check("t1_tx_hold", 32'(tx), 32'd1);
        check("t1_count", 32'(count), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_tx_start", 32'(tx), 32'd0);
        check("t1_count_pop", 32'(count), 32'd0);
        n = 1;
        while (busy && n < 100) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("t1_busy_len", 32'(n), 32'd40);
        wait_idle();

        for (int v = 0; v < 5; v++) begin
            push(tbl[v].d, tbl[v].frame, ok, c);
            valid = 1'b0;
            check("tbl_ok", 32'(ok), 32'd1);
            @(negedge clk);
            check("tbl_count", 32'(count), 32'(tbl[v].cnt));
            check("tbl_busy", 32'(busy), 32'd1);
            wait_idle();
        end

        push(8'hA3, 10'h346, ok, c);
        push(8'h0F, 10'h21E, ok, c);
        wait_idle();
        check("t2_gap", 32'(last_start - prev_start), 32'(10 * CPB));

        i = 0;
        guard = 0;
        held = 0;
        while (i < 6 && guard < 500) begin
            push(burst[i], {1'b1, burst[i], 1'b0}, ok, c);
            if (ok) i++;
            else begin
                if (held == 0) check("t3_full_count", 32'(c), 32'd4);
                held++;
            end
            guard++;
        end
        check("t3_all_pushed", 32'(i), 32'd6);
        check("t3_held_off", 32'(held > 0), 32'd1);
        wait_idle();

        push(8'hC1, {1'b1, 8'hC1, 1'b0}, ok, c);
        push(8'hD2, {1'b1, 8'hD2, 1'b0}, ok, c);
        push(8'hE3, {1'b1, 8'hE3, 1'b0}, ok, c);
        valid = 1'b0;
        repeat (38) @(posedge clk);
        push(8'hF4, {1'b1, 8'hF4, 1'b0}, ok, c);
        valid = 1'b0;
        check("t4_count_before", 32'(c), 32'd2);
        @(negedge clk);
        check("t4_count_after", 32'(count), 32'd2);
        wait_idle();

        push(8'h00, 10'h200, ok, c);
        valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        check("t5_tx_low", 32'(tx), 32'd0);
        nRst = 1'b0;
        rst_gen++;
        #1;
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_count", 32'(count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(ready), 32'd1);
        #6 nRst = 1'b1;
        @(negedge clk);
        push(8'h96, {1'b1, 8'h96, 1'b0}, ok, c);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
